irq_arbiter: RTL

Round-robin interrupt arbiter placed between up to N peripheral interrupt sources and the processor's single-request interrupt port. Rising edges on the source lines are latched into pending bits and gated by a software-writable mask. One pending source at a time is presented to the processor as a request ID. The processor's acknowledge and end handshake is routed back to the granted source only.

---
 rtl/irq_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/irq_arbiter.sv
// Round-robin interrupt arbiter: edge-latched, maskable sources funneled to a
// single processor request port, with the ack/end handshake routed to the winner.
module irq_arbiter #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [N_SRC-1:0] SRC_IRQ,
    output logic [N_SRC-1:0] SRC_IACK,
    output logic [N_SRC-1:0] SRC_IEND,
    input  logic             MASK_WE,
    input  logic [N_SRC-1:0] MASK_WDATA,
    output logic [N_SRC-1:0] MASK,
    output logic [N_SRC-1:0] PENDING,
    output logic             C_IRQ_VALID,
    output logic [ID_W-1:0]  C_IRQ_ID,
    input  logic             C_IACK,
    input  logic             C_IEND
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE, END_WAIT} state_t;

    state_t            state, state_nxt;
    logic [N_SRC-1:0]  src_irq_d, pending, mask, eligible, rise, pend_clr, grant_oh;
    logic [ID_W-1:0]   grant, grant_nxt, last_grant, last_grant_nxt;
    logic [ID_W-1:0]   pick_hi, pick_wrap, rr_pick;
    logic              hi_found, grant_elig, valid, iack_en, iend_en;

    assign rise     = SRC_IRQ & ~src_irq_d;
    assign eligible = pending & mask;

    // Lowest eligible index above last_grant wins; otherwise wrap to lowest overall.
    always_comb begin
        pick_hi   = '0;
        pick_wrap = '0;
        hi_found  = 1'b0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                pick_wrap = ID_W'(j);
                if (j > int'(last_grant)) begin
                    pick_hi  = ID_W'(j);
                    hi_found = 1'b1;
                end
            end
        end
        rr_pick = hi_found ? pick_hi : pick_wrap;
    end

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < N_SRC; i++)
            grant_oh[i] = (int'(grant) == i);
    end

    assign grant_elig = |(eligible & grant_oh);

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        pend_clr       = '0;
        valid          = 1'b0;
        iack_en        = 1'b0;
        iend_en        = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    grant_nxt = rr_pick;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                valid   = 1'b1;
                iack_en = 1'b1;
                // Withdrawn by a mask write: drop quietly, rotation untouched.
                if (!grant_elig) begin
                    state_nxt = IDLE;
                end else if (C_IACK) begin
                    pend_clr  = grant_oh;
                    state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                iack_en = 1'b1;
                iend_en = 1'b1;
                if (C_IEND) state_nxt = END_WAIT;
            end
            END_WAIT: begin
                iend_en = 1'b1;
                if (!C_IEND) begin
                    last_grant_nxt = grant;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            pending    <= '0;
            mask       <= '1;
            src_irq_d  <= '0;
            last_grant <= ID_W'(N_SRC - 1);
            grant      <= '0;
        end else begin
            state      <= state_nxt;
            // A fresh edge on the same cycle as its ack must survive.
            pending    <= (pending & ~pend_clr) | rise;
            if (MASK_WE) mask <= MASK_WDATA;
            src_irq_d  <= SRC_IRQ;
            last_grant <= last_grant_nxt;
            grant      <= grant_nxt;
        end
    end

    assign MASK        = mask;
    assign PENDING     = pending;
    assign C_IRQ_VALID = valid;
    assign C_IRQ_ID    = valid ? grant : '1;
    assign SRC_IACK    = {N_SRC{iack_en & C_IACK}} & grant_oh;
    assign SRC_IEND    = {N_SRC{iend_en & C_IEND}} & grant_oh;

endmodule
